// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp
//   Removes the CORDIC processing gain from the X/Y results of a CORDIC core.
//   In circular and hyperbolic modes, X and Y are multiplied by 1/K in Q16.16.
//   The multiply is a 17-cycle shift-add that reads one constant bit per cycle.
//   The product is then rescaled and saturated to the WIDTH-bit signed range.
//   In linear mode and in the reserved mode, X and Y pass through unchanged.
//   Z always passes through unchanged.
//
// Ports
//   clk                  rising-edge clock
//   rst                  synchronous, active-low reset
//   in_valid/in_ready    input strobe; the block accepts it only while idle
//   mode_coord           01 circular, 11 hyperbolic, 00 linear, 10 reserved
//   x_in, y_in, z_in     signed CORDIC results
//   out_valid/out_ready  output handshake; the result is held until accepted
//   x_out, y_out, z_out  signed compensated results
//   sat                  X or Y of the current result was clamped
//   overflow             sticky; an input strobe arrived while busy and was dropped
module cordic_gain_comp #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [1:0]       mode_coord,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             in_ready,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             out_valid,
  output logic             sat,
  output logic             overflow
);

  // 17-bit constant times a WIDTH-bit operand, plus one guard bit for the sign.
  localparam int ACC_W = WIDTH + 18;

  localparam logic [16:0] C_CIRC = 17'd39797;
  localparam logic [16:0] C_HYP  = 17'd79134;

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               bit_cnt_q, bit_cnt_d;
  logic [16:0]              coef_q, coef_d;
  logic [WIDTH-1:0]         x_op_q, x_op_d, y_op_q, y_op_d;
  logic signed [ACC_W-1:0]  x_acc_q, x_acc_d, y_acc_q, y_acc_d;
  logic [WIDTH-1:0]         x_res_q, x_res_d, y_res_q, y_res_d, z_res_q, z_res_d;
  logic                     sat_q, sat_d;
  logic                     out_valid_q, out_valid_d;
  logic                     overflow_q, overflow_d;

  logic signed [ACC_W-1:0]  x_term, y_term, x_sum, y_sum;
  logic [WIDTH:0]           x_clamp, y_clamp;

  // Rescale the accumulated product back to Q(FRAC).
  // The arithmetic shift floors toward -inf.
  // Bit WIDTH of the return value flags that the result was clamped.
  function automatic logic [WIDTH:0] clamp(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] scaled;
    scaled = acc >>> FRAC;
    if (scaled > MAX_V)      clamp = {1'b1, MAX_V[WIDTH-1:0]};
    else if (scaled < MIN_V) clamp = {1'b1, MIN_V[WIDTH-1:0]};
    else                     clamp = {1'b0, scaled[WIDTH-1:0]};
  endfunction

  // Shift-add datapath.
  // Each cycle handles one constant bit: the shifted operand is added only if that bit is set.
  // The sums are also what the last MUL cycle clamps, so the final term is included.
  always_comb begin
    x_term  = {{(ACC_W-WIDTH){x_op_q[WIDTH-1]}}, x_op_q} <<< bit_cnt_q;
    y_term  = {{(ACC_W-WIDTH){y_op_q[WIDTH-1]}}, y_op_q} <<< bit_cnt_q;
    x_sum   = coef_q[bit_cnt_q] ? (x_acc_q + x_term) : x_acc_q;
    y_sum   = coef_q[bit_cnt_q] ? (y_acc_q + y_term) : y_acc_q;
    x_clamp = clamp(x_sum);
    y_clamp = clamp(y_sum);
  end

  // Next-state and datapath control.
  // out_valid is registered, so it rises on the edge after the FSM enters DONE.
  // That gives 1 cycle of latency for the bypass modes and 18 for the scaled modes.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    coef_d      = coef_q;
    x_op_d      = x_op_q;
    y_op_d      = y_op_q;
    x_acc_d     = x_acc_q;
    y_acc_d     = y_acc_q;
    x_res_d     = x_res_q;
    y_res_d     = y_res_q;
    z_res_d     = z_res_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q;

    // A strobe that arrives while busy is lost.
    // This includes the cycle in which a DONE handshake completes.
    if (in_valid && (state_q != IDLE)) overflow_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_op_d    = x_in;
          y_op_d    = y_in;
          z_res_d   = z_in;
          x_acc_d   = '0;
          y_acc_d   = '0;
          bit_cnt_d = '0;
          if (mode_coord[0]) begin
            coef_d  = mode_coord[1] ? C_HYP : C_CIRC;
            state_d = MUL;
          end else begin
            x_res_d = x_in;
            y_res_d = y_in;
            sat_d   = 1'b0;
            state_d = DONE;
          end
        end
      end
      MUL: begin
        x_acc_d   = x_sum;
        y_acc_d   = y_sum;
        bit_cnt_d = 5'(bit_cnt_q + 5'd1);
        if (bit_cnt_q == 5'd16) begin
          x_res_d   = x_clamp[WIDTH-1:0];
          y_res_d   = y_clamp[WIDTH-1:0];
          sat_d     = x_clamp[WIDTH] | y_clamp[WIDTH];
          bit_cnt_d = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers, with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      coef_q      <= '0;
      x_op_q      <= '0;
      y_op_q      <= '0;
      x_acc_q     <= '0;
      y_acc_q     <= '0;
      x_res_q     <= '0;
      y_res_q     <= '0;
      z_res_q     <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      coef_q      <= coef_d;
      x_op_q      <= x_op_d;
      y_op_q      <= y_op_d;
      x_acc_q     <= x_acc_d;
      y_acc_q     <= y_acc_d;
      x_res_q     <= x_res_d;
      y_res_q     <= y_res_d;
      z_res_q     <= z_res_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  // in_ready is gated with rst so that it stays low throughout reset.
  assign in_ready  = rst && (state_q == IDLE);
  assign x_out     = x_res_q;
  assign y_out     = y_res_q;
  assign z_out     = z_res_q;
  assign sat       = sat_q;
  assign out_valid = out_valid_q;
  assign overflow  = overflow_q;

endmodule
